// File: rtl/vga_text_buffer_writer.sv
// -----------------------------------------------------------------------------
// vga_text_buffer_writer
//
// Owns the 13x12 character buffer read by the on-screen voltage table.
// Per-channel millivolt results arrive over a valid/ready handshake. Each one
// is clamped, converted to BCD by double-dabble, and written as a formatted
// 12-character row:  "CHnn d.dddV ".
// A registered read port serves ASCII codes to the font ROM, addressed by the
// draw stage.
//
// Ports
//   clk         system (pixel) clock, sole clock
//   rst         asynchronous reset, active-low
//   meas_valid  measurement offered
//   meas_ready  writer can accept a measurement (high only while idle)
//   meas_ch     channel index, 0..N_CH-1 valid
//   meas_mv     channel voltage in mV, unsigned
//   ch_err      one-cycle pulse after accepting a measurement with a bad channel
//   text_xy     read address = row*ROW_CHARS + col
//   char_code   ASCII at text_xy, one cycle of latency; space when out of range
// -----------------------------------------------------------------------------
module vga_text_buffer_writer #(
    parameter int N_CH      = 13,
    parameter int ROW_CHARS = 12,
    parameter int MV_MAX    = 9999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       meas_valid,
    output logic       meas_ready,
    input  logic [3:0] meas_ch,
    input  logic [13:0] meas_mv,
    output logic       ch_err,
    input  logic [7:0] text_xy,
    output logic [6:0] char_code
);

    localparam int CELLS = N_CH * ROW_CHARS;
    localparam int MV_W  = 14;

    typedef enum logic [1:0] {INIT, IDLE, CONV, WR} state_t;

    // Control registers
    state_t      state, state_next;
    logic [7:0]  init_addr, init_addr_next;
    logic [3:0]  row, row_next;
    logic [3:0]  col, col_next;
    logic [3:0]  cnt, cnt_next;
    logic        ch_err_next;

    // Conversion datapath (no reset needed; loaded before use)
    logic [13:0] bin, bin_next;
    logic [15:0] bcd, bcd_next;
    logic [29:0] dabble_shift;

    // Buffer write port
    logic        we;
    logic [7:0]  waddr;
    logic [6:0]  wdata;

    logic [6:0]  mem [0:CELLS-1];

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic [13:0] clamp_mv(input logic [13:0] mv);
        if (mv > 14'(MV_MAX))
            return 14'(MV_MAX);
        return mv;
    endfunction

    // One double-dabble correction: add 3 to every BCD nibble >= 5.
    function automatic logic [15:0] dabble_adj(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // ch*12 built from shifts; fits in 8 bits for every legal channel.
    function automatic logic [7:0] row_base(input logic [3:0] r);
        return ({4'b0, r} << 3) + ({4'b0, r} << 2);
    endfunction

    // Character at column c of row r, with BCD digits d.
    function automatic logic [6:0] fmt_char(input logic [3:0] r, input logic [3:0] c,
                                            input logic [15:0] d);
        logic [3:0] num;
        logic [3:0] tens;
        logic [3:0] units;
        logic [6:0] ch;
        num   = r + 4'd1;
        tens  = (num >= 4'd10) ? 4'd1 : 4'd0;
        units = (num >= 4'd10) ? (num - 4'd10) : num;
        case (c)
            4'd0:    ch = 7'h43;                     // 'C'
            4'd1:    ch = 7'h48;                     // 'H'
            4'd2:    ch = 7'h30 + {3'b0, tens};
            4'd3:    ch = 7'h30 + {3'b0, units};
            4'd5:    ch = 7'h30 + {3'b0, d[15:12]};
            4'd6:    ch = 7'h2E;                     // '.'
            4'd7:    ch = 7'h30 + {3'b0, d[11:8]};
            4'd8:    ch = 7'h30 + {3'b0, d[7:4]};
            4'd9:    ch = 7'h30 + {3'b0, d[3:0]};
            4'd10:   ch = 7'h56;                     // 'V'
            default: ch = 7'h20;                     // cols 4 and 11 are spaces
        endcase
        return ch;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        init_addr_next = init_addr;
        row_next       = row;
        col_next       = col;
        cnt_next       = cnt;
        bin_next       = bin;
        bcd_next       = bcd;
        ch_err_next    = 1'b0;
        meas_ready     = 1'b0;
        we             = 1'b0;
        waddr          = 8'd0;
        wdata          = 7'h20;
        dabble_shift   = {dabble_adj(bcd), bin} << 1;

        case (state)
            INIT: begin
                // row/col track init_addr so the formatter knows which cell it is on
                we             = 1'b1;
                waddr          = init_addr;
                wdata          = fmt_char(row, col, 16'h0000);
                init_addr_next = init_addr + 8'd1;
                if (col == 4'(ROW_CHARS - 1)) begin
                    col_next = 4'd0;
                    row_next = row + 4'd1;
                end else begin
                    col_next = col + 4'd1;
                end
                if (init_addr == 8'(CELLS - 1))
                    state_next = IDLE;
            end

            IDLE: begin
                meas_ready = 1'b1;
                if (meas_valid) begin
                    if (meas_ch < 4'(N_CH)) begin
                        row_next   = meas_ch;
                        col_next   = 4'd0;
                        cnt_next   = 4'd0;
                        bin_next   = clamp_mv(meas_mv);
                        bcd_next   = 16'h0000;
                        state_next = CONV;
                    end else begin
                        ch_err_next = 1'b1;
                    end
                end
            end

            CONV: begin
                {bcd_next, bin_next} = dabble_shift;
                cnt_next = cnt + 4'd1;
                if (cnt == 4'(MV_W - 1))
                    state_next = WR;
            end

            WR: begin
                we       = 1'b1;
                waddr    = row_base(row) + {4'b0, col};
                wdata    = fmt_char(row, col, bcd);
                col_next = col + 4'd1;
                if (col == 4'(ROW_CHARS - 1)) begin
                    col_next   = 4'd0;
                    state_next = IDLE;
                end
            end

            default: state_next = INIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            init_addr <= 8'd0;
            row       <= 4'd0;
            col       <= 4'd0;
            cnt       <= 4'd0;
            ch_err    <= 1'b0;
        end else begin
            state     <= state_next;
            init_addr <= init_addr_next;
            row       <= row_next;
            col       <= col_next;
            cnt       <= cnt_next;
            ch_err    <= ch_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Conversion datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        bin <= bin_next;
        bcd <= bcd_next;
    end

    // -------------------------------------------------------------------------
    // Character buffer: write port from FSM, registered read port.
    // A same-cell read and write return the old contents.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            char_code <= 7'h20;
        else if (text_xy < 8'(CELLS))
            char_code <= mem[text_xy];
        else
            char_code <= 7'h20;
    end

endmodule
